// File: rtl/apb_node_timeout.sv
// -----------------------------------------------------------------------------
// apb_node_timeout
//
// Parametrised APB 1-to-N demultiplexer with a decode-error response and a
// per-transfer watchdog.
//
// The upstream address is decoded against inclusive per-slave [start, end]
// ranges, and the lowest index wins when ranges overlap. The transfer is then
// forwarded to the selected downstream slave. Unmapped addresses get a
// zero-wait-state PSLVERR response. A slave that holds PREADY low for too long
// is abandoned and the upstream master gets a PSLVERR response.
//
// Handshake: these are standard APB semantics.
//   - A transfer starts with a setup cycle (psel=1, penable=0).
//   - It is followed by one or more access cycles (psel=1, penable=1).
//   - The transfer completes in the access cycle where pready=1. pslverr and
//     prdata are only meaningful in that cycle.
//   - pready is never asserted outside an access-phase response cycle.
//
// Ports
//   HCLK, HRESETn                   clock, asynchronous active-low reset
//   s_paddr/s_pwdata/s_pwrite       upstream request
//   s_psel/s_penable                upstream select and enable
//   s_prdata/s_pready/s_pslverr     upstream response
//   m_paddr/m_pwdata/m_pwrite       shared downstream request (pass-through)
//   m_psel[NB_SLAVES]               one-hot downstream select
//   m_penable                       shared downstream enable
//   m_prdata/m_pready/m_pslverr     packed per-slave responses
//
// Optional build macro APB_NODE_ERR_STATUS_EN adds error status capture:
//   err_addr_o   address of the last errored transfer
//   err_type_o   0 = decode error, 1 = timeout
//   err_irq_o    sticky error flag
//   err_clr_i    clears err_irq_o; an error in the same cycle wins
//
// The FSM state is held in 'state' (type apb_node_state_e) for observation.
// -----------------------------------------------------------------------------
module apb_node_timeout #(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] START_ADDR =
        {32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000},
    parameter logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] END_ADDR =
        {32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF},
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                HCLK,
    input  logic                                HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]           s_paddr,
    input  logic [APB_DATA_WIDTH-1:0]           s_pwdata,
    input  logic                                s_pwrite,
    input  logic                                s_psel,
    input  logic                                s_penable,
    output logic [APB_DATA_WIDTH-1:0]           s_prdata,
    output logic                                s_pready,
    output logic                                s_pslverr,
    output logic [APB_ADDR_WIDTH-1:0]           m_paddr,
    output logic [APB_DATA_WIDTH-1:0]           m_pwdata,
    output logic                                m_pwrite,
    output logic [NB_SLAVES-1:0]                m_psel,
    output logic                                m_penable,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata,
    input  logic [NB_SLAVES-1:0]                m_pready,
    input  logic [NB_SLAVES-1:0]                m_pslverr
`ifdef APB_NODE_ERR_STATUS_EN
    ,
    output logic [APB_ADDR_WIDTH-1:0]           err_addr_o,
    output logic                                err_type_o,
    output logic                                err_irq_o,
    input  logic                                err_clr_i
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES <= 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = (NB_SLAVES <= 1) ? 1 : $clog2(NB_SLAVES);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W:0] TOUT_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DECERR = 2'd2,
        TOUT   = 2'd3
    } apb_node_state_e;

    apb_node_state_e      state;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 dec_hit;
    logic [IDX_W-1:0]     dec_idx;
    logic                 sel_ready;
    logic                 sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;
    logic                 timeout_hit;

    // Request signals are shared by all slaves; only m_psel steers the transfer.
    assign m_paddr  = s_paddr;
    assign m_pwdata = s_pwdata;
    assign m_pwrite = s_pwrite;

    // Address decode. The loop walks downwards so that the lowest matching
    // index is the one left in dec_idx.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            if ((s_paddr >= START_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
                (s_paddr <= END_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    // Response mux for the slave latched at setup.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = m_pready[i];
                sel_err   = m_pslverr[i];
                sel_rdata = m_prdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    // The abort fires on the wait cycle that would bring the counter to
    // TIMEOUT_CYCLES. With TIMEOUT_CYCLES=N, the upstream master sees N
    // unanswered access cycles followed by the error cycle.
    assign timeout_hit = WDOG_EN && (({1'b0, cnt_q} + 1'b1) == TOUT_LIM);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (s_psel && !s_penable) begin
                        if (dec_hit) begin
                            state <= ACCESS;
                            idx_q <= dec_idx;
                        end else begin
                            state <= DECERR;
                        end
                    end
                end
                ACCESS: begin
                    if (!s_psel) begin
                        // Master gave up mid-transfer: drop it silently.
                        state <= IDLE;
                        cnt_q <= '0;
                    end else if (s_penable) begin
                        if (sel_ready) begin
                            state <= IDLE;
                            cnt_q <= '0;
                        end else if (timeout_hit) begin
                            state <= TOUT;
                            cnt_q <= '0;
                        end else if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DECERR: begin
                    if (!s_psel || s_penable) begin
                        state <= IDLE;
                    end
                end
                TOUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_psel    = '0;
        m_penable = 1'b0;
        s_pready  = 1'b0;
        s_pslverr = 1'b0;
        s_prdata  = '0;
        case (state)
            IDLE: begin
                // Select is raised in the setup cycle itself, before idx_q is loaded.
                if (s_psel && !s_penable && dec_hit) begin
                    for (int i = 0; i < NB_SLAVES; i++) begin
                        m_psel[i] = (dec_idx == IDX_W'(i));
                    end
                end
            end
            ACCESS: begin
                for (int i = 0; i < NB_SLAVES; i++) begin
                    m_psel[i] = (idx_q == IDX_W'(i));
                end
                m_penable = s_penable;
                s_pready  = sel_ready;
                s_pslverr = sel_err;
                s_prdata  = sel_rdata;
            end
            DECERR: begin
                if (s_penable) begin
                    s_pready  = 1'b1;
                    s_pslverr = 1'b1;
                end
            end
            TOUT: begin
                s_pready  = 1'b1;
                s_pslverr = 1'b1;
            end
            default: begin
                m_psel = '0;
            end
        endcase
    end

`ifdef APB_NODE_ERR_STATUS_EN
    logic err_dec;
    logic err_tout;

    assign err_dec  = (state == DECERR) && s_penable;
    assign err_tout = (state == TOUT);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_addr_o <= '0;
            err_type_o <= 1'b0;
            err_irq_o  <= 1'b0;
        end else if (err_dec || err_tout) begin
            err_addr_o <= s_paddr;
            err_type_o <= err_tout;
            err_irq_o  <= 1'b1;
        end else if (err_clr_i) begin
            err_irq_o  <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/apb_node_timeout.md
Name: apb_node_timeout

Overview:
- Parametrised APB 1-to-N demultiplexer for the SoC peripheral bus. It decodes the upstream transfer address against per-slave start/end ranges and forwards the transfer to one downstream slave.
- It replaces the fixed-count, fixed-map peripheral fan-out with a generic node.
- Adds a decode-error response for unmapped addresses and a per-transfer watchdog that aborts hung slaves with PSLVERR.
- Sits between the AXI/APB bridge and the peripheral slaves: UART, GPIO, SPI, timer and others.

Parameters:
- NB_SLAVES, 4, number of downstream slave ports (1..32).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- START_ADDR, {32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000}, packed NB_SLAVES*APB_ADDR_WIDTH; slice i is the inclusive start of slave i.
- END_ADDR, {32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF}, packed; slice i is the inclusive end of slave i.
- TIMEOUT_CYCLES, 1024, access-phase wait cycles before abort; 0 disables the watchdog.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  async active-low reset.
- s_paddr  in  APB_ADDR_WIDTH  upstream address.
- s_pwdata  in  APB_DATA_WIDTH  upstream write data.
- s_pwrite  in  1  upstream write.
- s_psel  in  1  upstream select.
- s_penable  in  1  upstream enable.
- s_prdata  out  APB_DATA_WIDTH  upstream read data.
- s_pready  out  1  upstream ready.
- s_pslverr  out  1  upstream error.
- m_paddr  out  APB_ADDR_WIDTH  shared downstream address.
- m_pwdata  out  APB_DATA_WIDTH  shared downstream write data.
- m_pwrite  out  1  shared downstream write.
- m_psel  out  NB_SLAVES  one-hot downstream select.
- m_penable  out  1  shared downstream enable.
- m_prdata  in  NB_SLAVES*APB_DATA_WIDTH  packed slave read data.
- m_pready  in  NB_SLAVES  slave ready.
- m_pslverr  in  NB_SLAVES  slave error.

Behaviour:
- Clock and reset: HCLK is the only clock. HRESETn is asynchronous and active-low.
- Reset values: FSM = IDLE, timeout counter = 0, m_psel = 0, m_penable = 0, s_pready = 0, s_pslverr = 0, s_prdata = 0.
- Decode (combinational):
  - hit[i] = (s_paddr >= START[i]) && (s_paddr <= END[i]).
  - The lowest index wins on overlap.
  - No hit means decode error.
- m_paddr, m_pwdata and m_pwrite pass through s_* combinationally.
- FSM states:
  - IDLE:
    - If s_psel && !s_penable (setup phase) and there is a hit: go to ACCESS with the slave index latched; m_psel[idx] = 1 combinationally this cycle.
    - If there is no hit: go to DECERR; m_psel stays 0.
  - ACCESS:
    - m_psel[idx] = 1 and m_penable = s_penable.
    - s_pready, s_prdata and s_pslverr mux from the latched idx.
    - When s_penable && m_pready[idx]: transfer completes, go to IDLE, clear the counter.
    - While s_penable && !m_pready[idx]: counter increments.
    - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: go to TOUT.
  - DECERR: when s_penable, drive s_pready = 1, s_pslverr = 1, s_prdata = 0 for one cycle (zero wait states), then go to IDLE.
  - TOUT:
    - m_psel = 0 and m_penable = 0 (slave abandoned).
    - Drive s_pready = 1, s_pslverr = 1, s_prdata = 0 for exactly one cycle, then go to IDLE.
- Abort timing: total upstream wait on a hung slave is TIMEOUT_CYCLES+1 access cycles.
- Late slave response: a late m_pready from an abandoned slave is ignored. The next transfer may target any slave.
- Upstream protocol violation: s_psel dropped mid-ACCESS returns to IDLE with no response and clears the counter.
- Outside IDLE/ACCESS/DECERR/TOUT response cycles, s_pready = 0.
- Back-to-back transfers: setup immediately following completion is accepted with no bubble.
- Reset mid-transfer: everything returns to reset values asynchronously; no response is issued.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1, and it saturates.

Optional Feature:
- Macro: APB_NODE_ERR_STATUS_EN.
- When defined, adds the following ports:
  - err_addr_o out APB_ADDR_WIDTH.
  - err_type_o out 1: 0 = decode error, 1 = timeout.
  - err_irq_o out 1: sticky.
  - err_clr_i in 1.
- On each DECERR/TOUT response cycle, err_addr_o captures s_paddr, err_type_o captures the type, and err_irq_o sets.
- err_clr_i clears err_irq_o. If an error occurs in the same cycle as err_clr_i, the set wins.
- Reset values of the added outputs are all 0.
- When not defined: the ports are absent and there are no extra flops.

Test Plan:
- Read 0x1A10_1004, GPIO slave ready on first access cycle, m_prdata[1] = 0xCAFE_0001 -> m_psel = 4'b0010; s_prdata = 0xCAFE_0001, s_pready = 1, s_pslverr = 0, zero wait states.
- Write 0x1A10_2010 data 0x55, SPI slave holds pready low 3 cycles -> s_pready asserts on 4th access cycle; m_pwdata = 0x55, m_pwrite = 1 throughout.
- Read 0x1A10_8000 (unmapped) -> m_psel = 0; s_pready = 1, s_pslverr = 1, s_prdata = 0 in first access cycle; with macro: err_addr_o = 0x1A10_8000, err_type_o = 0, err_irq_o = 1.
- TIMEOUT_CYCLES = 8, timer slave never ready -> s_pready = 1 and s_pslverr = 1 on 9th access cycle; m_psel = 0 that cycle; with macro: err_type_o = 1.
- Back-to-back UART then TIMER reads, then slave 3 asserts a stale pready during the UART transfer -> only slave 0 data returned, no spurious completion.
- Assert HRESETn low mid-ACCESS -> m_psel = 0, m_penable = 0 and s_pready = 0 immediately; the next transfer after release completes normally.
